// File: rtl/qam_stream_arbiter.sv
// qam_stream_arbiter: packet-locked round-robin arbiter sharing one QAM modulator among NUM_CH Avalon-ST sources.
// Optional QAM_ARB_CHANNEL_TAG_EN adds aso_out0_channel, the grant index registered alongside each output beat.
module qam_stream_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clock_clk,
    input  logic                         reset_reset,
    input  logic [NUM_CH*DATA_WIDTH-1:0] asi_in_data,
    input  logic [NUM_CH-1:0]            asi_in_valid,
    output logic [NUM_CH-1:0]            asi_in_ready,
    input  logic [NUM_CH-1:0]            asi_in_startofpacket,
    input  logic [NUM_CH-1:0]            asi_in_endofpacket,
    output logic [DATA_WIDTH-1:0]        aso_out0_data,
    output logic                         aso_out0_valid,
    input  logic                         aso_out0_ready,
    output logic                         aso_out0_startofpacket,
    output logic                         aso_out0_endofpacket,
`ifdef QAM_ARB_CHANNEL_TAG_EN
    output logic [$clog2(NUM_CH)-1:0]    aso_out0_channel,
`endif
    output logic [7:0]                   drop_count
);

    localparam int CH_W = $clog2(NUM_CH);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [CH_W-1:0]         grant_q, grant_d;
    logic [CH_W-1:0]         last_q, last_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    out_sop_q, out_sop_d;
    logic                    out_eop_q, out_eop_d;
    logic [CH_W-1:0]         out_chan_q, out_chan_d;
    logic [7:0]              drop_q, drop_d;

    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    sel_valid;
    logic                    sel_sop;
    logic                    sel_eop;
    logic                    found;
    logic [CH_W-1:0]         pick;
    logic                    grant_ready;
    logic [NUM_CH-1:0]       stray;
    logic [8:0]              drop_sum;

    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_sop   = 1'b0;
        sel_eop   = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant_q == CH_W'(c)) begin
                sel_data  = asi_in_data[c*DATA_WIDTH +: DATA_WIDTH];
                sel_valid = asi_in_valid[c];
                sel_sop   = asi_in_startofpacket[c];
                sel_eop   = asi_in_endofpacket[c];
            end
        end
    end

    // Round-robin search: offset 0 is the channel right after the last one served.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int off = 0; off < NUM_CH; off++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!found && asi_in_valid[c] && asi_in_startofpacket[c]
                    && (c == (int'(last_q) + 1 + off) % NUM_CH)) begin
                    found = 1'b1;
                    pick  = CH_W'(c);
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_d       = last_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_sop_d    = out_sop_q;
        out_eop_d    = out_eop_q;
        out_chan_d   = out_chan_q;
        drop_d       = drop_q;
        asi_in_ready = '0;
        stray        = '0;
        drop_sum     = {1'b0, drop_q};
        grant_ready  = 1'b0;

        if (out_valid_q && aso_out0_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                stray        = asi_in_valid & ~asi_in_startofpacket;
                asi_in_ready = stray;
                for (int c = 0; c < NUM_CH; c++) begin
                    if (stray[c]) begin
                        drop_sum = drop_sum + 9'd1;
                    end
                end
                drop_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
                if (found) begin
                    grant_d = pick;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                grant_ready = !out_valid_q || aso_out0_ready;
                for (int c = 0; c < NUM_CH; c++) begin
                    if (grant_q == CH_W'(c)) begin
                        asi_in_ready[c] = grant_ready;
                    end
                end
                if (grant_ready && sel_valid) begin
                    out_valid_d = 1'b1;
                    out_data_d  = sel_data;
                    out_sop_d   = sel_sop;
                    out_eop_d   = sel_eop;
                    out_chan_d  = grant_q;
                    if (sel_eop) begin
                        last_d  = grant_q;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Sources must see no acceptance while the block is held in reset.
        if (reset_reset) begin
            asi_in_ready = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock_clk) begin
        if (reset_reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            last_q      <= CH_W'(NUM_CH - 1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_chan_q  <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_chan_q  <= out_chan_d;
            drop_q      <= drop_d;
        end
    end

    assign aso_out0_data          = out_data_q;
    assign aso_out0_valid         = out_valid_q;
    assign aso_out0_startofpacket = out_sop_q;
    assign aso_out0_endofpacket   = out_eop_q;
    assign drop_count             = drop_q;
`ifdef QAM_ARB_CHANNEL_TAG_EN
    assign aso_out0_channel       = out_chan_q;
`endif

endmodule

// File: tb/tb_qam_stream_arbiter.sv
// Self-checking bench for qam_stream_arbiter: queue-based reference model plus directed literal checks.
// Honours QAM_ARB_CHANNEL_TAG_EN when the design is built with it.
module tb_qam_stream_arbiter;

    localparam int NUM_CH = 4;
    localparam int DW     = 32;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
    } beat_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        int            ch;
        int            cyc;
    } obs_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NUM_CH*DW-1:0]   asi_in_data = '0;
    logic [NUM_CH-1:0]      asi_in_valid = '0;
    logic [NUM_CH-1:0]      asi_in_ready;
    logic [NUM_CH-1:0]      asi_in_sop = '0;
    logic [NUM_CH-1:0]      asi_in_eop = '0;
    logic [DW-1:0]          aso_out0_data;
    logic                   aso_out0_valid;
    logic                   out_ready = 1'b1;
    logic                   aso_out0_sop;
    logic                   aso_out0_eop;
    logic [7:0]             drop_count;
`ifdef QAM_ARB_CHANNEL_TAG_EN
    logic [$clog2(NUM_CH)-1:0] aso_out0_channel;
`endif

    qam_stream_arbiter #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW)) dut (
        .clock_clk              (clk),
        .reset_reset            (rst),
        .asi_in_data            (asi_in_data),
        .asi_in_valid           (asi_in_valid),
        .asi_in_ready           (asi_in_ready),
        .asi_in_startofpacket   (asi_in_sop),
        .asi_in_endofpacket     (asi_in_eop),
        .aso_out0_data          (aso_out0_data),
        .aso_out0_valid         (aso_out0_valid),
        .aso_out0_ready         (out_ready),
        .aso_out0_startofpacket (aso_out0_sop),
        .aso_out0_endofpacket   (aso_out0_eop),
`ifdef QAM_ARB_CHANNEL_TAG_EN
        .aso_out0_channel       (aso_out0_channel),
`endif
        .drop_count             (drop_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int valid_pct  = 100;
    int ready_mode = 0;   // 0: always ready, 1: toggle, 2: random

    beat_t src_q[NUM_CH][$];
    obs_t  m_out_q[$];
    obs_t  out_log[$];
    logic [NUM_CH-1:0] take = '0;

    // Reference model state: packet lock, last served channel, drop counter.
    bit    m_init = 0;
    bit    m_busy = 0;
    int    m_grant = 0;
    int    m_last = NUM_CH - 1;
    int    m_drop = 0;
    bit    in_v[NUM_CH];
    bit    in_s[NUM_CH];
    bit    in_e[NUM_CH];
    logic [DW-1:0] in_d[NUM_CH];
    bit    exp_rdy[NUM_CH];
    logic [NUM_CH-1:0] exp_rdy_v;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Compare process: checks the DUT against the model, then advances the model over the coming edge.
    always @(negedge clk) begin
        obs_t o;
        int   c;
        int   n_stray;
        cyc++;
        take = asi_in_valid & asi_in_ready;
        for (int k = 0; k < NUM_CH; k++) begin
            in_v[k]    = asi_in_valid[k];
            in_s[k]    = asi_in_sop[k];
            in_e[k]    = asi_in_eop[k];
            in_d[k]    = asi_in_data[k*DW +: DW];
            exp_rdy[k] = 1'b0;
        end
        if (!rst) begin
            if (!m_busy) begin
                for (int k = 0; k < NUM_CH; k++) exp_rdy[k] = in_v[k] && !in_s[k];
            end else begin
                exp_rdy[m_grant] = (m_out_q.size() == 0) || out_ready;
            end
        end
        for (int k = 0; k < NUM_CH; k++) exp_rdy_v[k] = exp_rdy[k];

        if (m_init) begin
            check("in_ready", 64'(asi_in_ready), 64'(exp_rdy_v));
            check("out_valid", 64'(aso_out0_valid), 64'(m_out_q.size() != 0));
            if (m_out_q.size() != 0) begin
                check("out_data", 64'(aso_out0_data), 64'(m_out_q[0].data));
                check("out_sop", 64'(aso_out0_sop), 64'(m_out_q[0].sop));
                check("out_eop", 64'(aso_out0_eop), 64'(m_out_q[0].eop));
`ifdef QAM_ARB_CHANNEL_TAG_EN
                check("out_channel", 64'(aso_out0_channel), 64'(m_out_q[0].ch));
`endif
            end
            check("drop_count", 64'(drop_count), 64'(m_drop));
            if (aso_out0_valid && out_ready) begin
                o.data = aso_out0_data;
                o.sop  = aso_out0_sop;
                o.eop  = aso_out0_eop;
`ifdef QAM_ARB_CHANNEL_TAG_EN
                o.ch   = int'(aso_out0_channel);
`else
                o.ch   = -1;
`endif
                o.cyc  = cyc;
                out_log.push_back(o);
            end
        end

        if (rst) begin
            m_busy = 0;
            m_last = NUM_CH - 1;
            m_drop = 0;
            m_out_q.delete();
            m_init = 1;
        end else begin
            if (m_out_q.size() != 0 && out_ready) void'(m_out_q.pop_front());
            if (!m_busy) begin
                n_stray = 0;
                for (int k = 0; k < NUM_CH; k++) if (exp_rdy[k] && in_v[k]) n_stray++;
                m_drop = (m_drop + n_stray > 255) ? 255 : m_drop + n_stray;
                for (int k = 1; k <= NUM_CH; k++) begin
                    c = (m_last + k) % NUM_CH;
                    if (!m_busy && in_v[c] && in_s[c]) begin
                        m_busy  = 1;
                        m_grant = c;
                    end
                end
            end else if (in_v[m_grant] && exp_rdy[m_grant]) begin
                o.data = in_d[m_grant];
                o.sop  = in_s[m_grant];
                o.eop  = in_e[m_grant];
                o.ch   = m_grant;
                o.cyc  = 0;
                m_out_q.push_back(o);
                if (in_e[m_grant]) begin
                    m_busy = 0;
                    m_last = m_grant;
                end
            end
        end
    end

    task automatic drive();
        logic [NUM_CH*DW-1:0] d = '0;
        logic [NUM_CH-1:0]    v = '0;
        logic [NUM_CH-1:0]    s = '0;
        logic [NUM_CH-1:0]    e = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (src_q[k].size() != 0 && $urandom_range(99) < valid_pct) begin
                v[k]           = 1'b1;
                d[k*DW +: DW]  = src_q[k][0].data;
                s[k]           = src_q[k][0].sop;
                e[k]           = src_q[k][0].eop;
            end
        end
        asi_in_data  = d;
        asi_in_valid = v;
        asi_in_sop   = s;
        asi_in_eop   = e;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = !out_ready;
            default: out_ready = ($urandom_range(3) != 0);
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (take[k] && src_q[k].size() != 0) void'(src_q[k].pop_front());
        end
        drive();
    endtask

    function automatic bit all_empty();
        for (int k = 0; k < NUM_CH; k++) if (src_q[k].size() != 0) return 0;
        return 1;
    endfunction

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (!(all_empty() && m_out_q.size() == 0) && n < budget) begin
            step();
            n++;
        end
        n_tests++;
        if (n >= budget) begin
            n_fail++;
            $display("FAIL %s: timed out after %0d cycles with traffic outstanding", name, n);
        end
    endtask

    task automatic reset_dut(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) step();
        rst = 1'b0;
    endtask

    task automatic push(input int ch, input logic [DW-1:0] data, input logic sop, input logic eop);
        beat_t b;
        b.data = data;
        b.sop  = sop;
        b.eop  = eop;
        src_q[ch].push_back(b);
    endtask

    task automatic clear_sources();
        for (int k = 0; k < NUM_CH; k++) src_q[k].delete();
        drive();
    endtask

    initial begin
        int exp_ch[5] = '{0, 1, 2, 3, 0};
        int n_pkts;
        int n_beats;
        int n_strays;
        int len;
        int ch;
        int guard;

        // Reset with every channel presenting an SOP, then round-robin over 4-beat packets.
        for (int k = 0; k < NUM_CH; k++)
            for (int b = 0; b < 4; b++) push(k, DW'(k * 16 + b), b == 0, b == 3);
        for (int b = 0; b < 4; b++) push(0, DW'(32'h100 + b), b == 0, b == 3);
        drive();
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_in_ready", 64'(asi_in_ready), 64'(0));
            check("rst_out_valid", 64'(aso_out0_valid), 64'(0));
            check("rst_drop_count", 64'(drop_count), 64'(0));
        end
        out_log.delete();
        rst = 1'b0;
        wait_done(500, "round_robin");
        check("rr_beats", 64'(out_log.size()), 64'(20));
        if (out_log.size() == 20) begin
            for (int p = 0; p < 5; p++) begin
                check("rr_order", 64'(out_log[p*4].data[7:4]), 64'(exp_ch[p]));
                check("rr_sop", 64'(out_log[p*4].sop), 64'(1));
                check("rr_eop", 64'(out_log[p*4+3].eop), 64'(1));
            end
            for (int i = 1; i < 20; i++)
                check("rr_spacing", 64'(out_log[i].cyc - out_log[i-1].cyc), 64'((i % 4 == 0) ? 2 : 1));
        end

        // Backpressure: ready toggles every cycle during an 8-beat ch2 packet.
        clear_sources();
        reset_dut(2);
        out_log.delete();
        for (int b = 0; b < 8; b++) push(2, DW'(32'hA0 + b), b == 0, b == 7);
        ready_mode = 1;
        drive();
        wait_done(200, "backpressure");
        ready_mode = 0;
        check("bp_beats", 64'(out_log.size()), 64'(8));
        if (out_log.size() == 8) begin
            for (int b = 0; b < 8; b++) check("bp_data", 64'(out_log[b].data), 64'(32'hA0 + b));
            check("bp_sop", 64'(out_log[0].sop), 64'(1));
            check("bp_eop", 64'(out_log[7].eop), 64'(1));
        end

        // Stray beats on ch1 and ch3, then saturation.
        clear_sources();
        reset_dut(2);
        for (int i = 0; i < 3; i++) begin
            push(1, DW'(32'h5100 + i), 1'b0, 1'b0);
            push(3, DW'(32'h5300 + i), 1'b0, 1'b0);
        end
        drive();
        wait_done(50, "stray");
        check("stray_drop6", 64'(drop_count), 64'(6));
        for (int i = 0; i < 150; i++) begin
            push(1, DW'(i), 1'b0, 1'b0);
            push(3, DW'(i), 1'b0, 1'b0);
        end
        drive();
        wait_done(400, "stray_sat");
        check("stray_drop_sat", 64'(drop_count), 64'(255));

        // Single-beat packet on ch1 while ch2 waits with an SOP.
        clear_sources();
        reset_dut(2);
        out_log.delete();
        push(1, 32'h11, 1'b1, 1'b1);
        push(2, 32'h21, 1'b1, 1'b0);
        push(2, 32'h22, 1'b0, 1'b1);
        drive();
        wait_done(50, "single_beat");
        check("sb_beats", 64'(out_log.size()), 64'(3));
        if (out_log.size() == 3) begin
            check("sb_data", 64'(out_log[0].data), 64'(32'h11));
            check("sb_sop_eop", 64'({out_log[0].sop, out_log[0].eop}), 64'(2'b11));
            check("sb_next_ch2", 64'(out_log[1].data), 64'(32'h21));
`ifdef QAM_ARB_CHANNEL_TAG_EN
            check("sb_tag_first", 64'(out_log[0].ch), 64'(1));
            check("sb_tag_next", 64'(out_log[1].ch), 64'(2));
`endif
        end

        // Reset in the middle of a 6-beat ch0 packet.
        clear_sources();
        reset_dut(2);
        out_log.delete();
        for (int b = 1; b <= 6; b++) push(0, DW'(b), b == 1, b == 6);
        drive();
        guard = 0;
        while (src_q[0].size() > 3 && guard < 50) begin
            step();
            guard++;
        end
        check("mid_reach_beat3", 64'(src_q[0].size()), 64'(3));
        rst = 1'b1;
        step();
        check("mid_out_valid", 64'(aso_out0_valid), 64'(0));
        rst = 1'b0;
        wait_done(50, "mid_reset");
        check("mid_drop3", 64'(drop_count), 64'(3));

        // Randomized traffic against the model.
        clear_sources();
        reset_dut(2);
        out_log.delete();
        n_beats  = 0;
        n_strays = 0;
        n_pkts   = 200;
        for (int p = 0; p < n_pkts; p++) begin
            ch  = int'($urandom_range(NUM_CH - 1));
            len = int'($urandom_range(6, 1));
            if ($urandom_range(9) == 0) begin
                push(ch, $urandom, 1'b0, 1'b0);
                n_strays++;
            end
            for (int b = 0; b < len; b++) push(ch, $urandom, b == 0, b == len - 1);
            n_beats += len;
        end
        valid_pct  = 75;
        ready_mode = 2;
        drive();
        wait_done(20000, "random");
        check("rand_beats", 64'(out_log.size()), 64'(n_beats));
        check("rand_drops", 64'(drop_count), 64'(n_strays));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/qam_stream_arbiter.md
# qam_stream_arbiter

Packet-locked round-robin arbiter that shares one QAM modulation datapath between `NUM_CH` Avalon-ST symbol sources. Each source delivers packed 2-bit QAM symbol words; the arbiter grants one channel per packet (SOP to EOP). It forwards that channel's beats through a registered output stage to the modulator sink. Stray beats that arrive outside a packet are discarded and counted.

## Interface
- `NUM_CH`, 4: number of requesting channels (2..8)
- `DATA_WIDTH`, 32: symbol word width, i.e. 16 symbols × 2 bits; must equal the modulator sink width
- `clock_clk` in 1: single clock; all logic rising-edge
- `reset_reset` in 1: synchronous, active-high reset
- `asi_in_data` in NUM_CH*DATA_WIDTH: channel c occupies bits [(c+1)*DATA_WIDTH-1 -: DATA_WIDTH]
- `asi_in_valid` in NUM_CH: per-channel valid
- `asi_in_ready` out NUM_CH: per-channel ready
- `asi_in_startofpacket` in NUM_CH: per-channel SOP
- `asi_in_endofpacket` in NUM_CH: per-channel EOP
- `aso_out0_data` out DATA_WIDTH: forwarded symbol word
- `aso_out0_valid` out 1: output beat valid
- `aso_out0_ready` in 1: downstream (modulator) ready
- `aso_out0_startofpacket` out 1: forwarded SOP
- `aso_out0_endofpacket` out 1: forwarded EOP
- `drop_count` out 8: saturating count of discarded stray beats

## Operation
- The FSM has two states, IDLE and BUSY, plus a register `grant` (index) and a register `last` (last granted channel).
- **IDLE:**
  - Candidates are the channels with `valid && sop`.
  - Search starts at `last+1` mod NUM_CH, ascending with wrap. The first candidate found is loaded into `grant`, and the FSM moves to BUSY.
  - No candidate: stay in IDLE.
  - All `asi_in_ready` are low except for stray channels (below).
- **Stray beats (IDLE only):**
  - A stray beat is a channel with `valid && !sop`.
  - It gets `asi_in_ready[c]=1` in the same cycle and the beat is consumed and discarded.
  - `drop_count` increments by the number of stray beats that cycle and saturates at 255.
  - An SOP beat is never stray.
- **BUSY:**
  - `asi_in_ready[grant] = !aso_out0_valid || aso_out0_ready`. All other readies are 0, so those channels hold their beats.
  - On a granted transfer, the data, SOP and EOP are loaded into the output register and `aso_out0_valid` is set.
  - A transfer with EOP=1 sets `last←grant` and moves the FSM to IDLE in the same edge.
  - SOP seen mid-packet is forwarded unchanged; there is no check.
- **Output register:**
  - `aso_out0_valid` clears when `aso_out0_ready` is high and no new beat loads.
  - Data is held stable while `valid && !ready`.
- **Reset values:**
  - `aso_out0_valid/startofpacket/endofpacket`=0, `aso_out0_data`=0, `asi_in_ready`=0, `drop_count`=0.
  - FSM is in IDLE, `grant`=0, `last`=NUM_CH-1, so channel 0 has first priority.
- **Reset mid-packet:**
  - The packet is abandoned and the output valid drops.
  - Remaining non-SOP beats of that channel are later discarded as strays.

## Timing
- Arbitration takes 1 cycle: SOP is presented in IDLE at cycle N, the grant is registered at N+1, and the SOP beat transfers at N+1 at the earliest.
- Input-to-output latency is 1 cycle: a beat accepted at edge N is visible on `aso_out0_*` after edge N.
- Packet gap: EOP transfer returns the FSM to IDLE, so at least one idle output cycle separates consecutive packets.
- Steady-state throughput is 1 beat/cycle while `aso_out0_ready`=1.
- Single-beat packet (SOP=EOP=1): IDLE→BUSY→IDLE, occupying 2 cycles.
- Readies are combinational from state and `aso_out0_ready`. They have no combinational dependence on `asi_in_valid` except for the stray-ready path in IDLE.

## Configuration
- `QAM_ARB_CHANNEL_TAG_EN`: when defined, adds output `aso_out0_channel` ($clog2(NUM_CH) bits). It is registered alongside data and equals the grant index of the current beat; its reset value is 0.
- When undefined, the port is absent and behaviour is otherwise identical.

## Test plan
- **Reset:** hold `reset_reset` 3 cycles with all inputs valid → all readies 0, `aso_out0_valid`=0, `drop_count`=0 throughout. After release, channel 0 is granted first.
- **Round-robin:** ch0..ch3 each present 4-beat packets continuously, data = {ch,beat} → output order ch0,ch1,ch2,ch3,ch0. Each packet is contiguous, with exactly one idle cycle between packets.
- **Backpressure:**
  - Toggle `aso_out0_ready` 1/0 each cycle during a ch2 packet of 8 beats 0xA0..0xA7 → all 8 beats arrive in order with no duplicates.
  - Data is stable while stalled.
  - `asi_in_ready[2]` is low on stall cycles where the output is full.
- **Stray drop:** in IDLE, ch1 and ch3 present valid without SOP for 3 cycles → 6 beats consumed, `drop_count`=6. Then drive 300 strays → `drop_count` saturates at 255.
- **Single-beat and contention:** ch1 presents SOP+EOP beat 0x11 while ch2 waits with an SOP → 0x11 is output with SOP=EOP=1 and ch2 is granted next. With the macro enabled, `aso_out0_channel` = 1 then 2.
- **Reset mid-packet:** reset asserted at beat 3 of a 6-beat ch0 packet → output valid is 0 the cycle after reset. Post-reset beats 4-6 without SOP are dropped, giving `drop_count`=3.
